// File: rtl/thermo_frame_decoder_if.sv
// -----------------------------------------------------------------------------
// thermo_frame_decoder_if
//   Bundles the serial input stream and the valid/ready result channel of
//   thermo_frame_decoder.
//
//   Signals:
//     ser_in, frame_sync      serial bit and frame-start marker (into decoder)
//     out_level/blank/err     registered decode result (out of decoder)
//     out_valid, out_ready    result handshake
//     overrun, sync_err       one-cycle event pulses (out of decoder)
//
//   Modports:
//     master  generator/consumer side (drives ser_in, frame_sync, out_ready)
//     slave   the decoder itself
// -----------------------------------------------------------------------------
interface thermo_frame_decoder_if #(
  parameter int LEVEL_W = 3
);
  logic               ser_in;
  logic               frame_sync;
  logic [LEVEL_W-1:0] out_level;
  logic               out_blank;
  logic               out_err;
  logic               out_valid;
  logic               out_ready;
  logic               overrun;
  logic               sync_err;

  modport master (
    output ser_in, frame_sync, out_ready,
    input  out_level, out_blank, out_err, out_valid, overrun, sync_err
  );

  modport slave (
    input  ser_in, frame_sync, out_ready,
    output out_level, out_blank, out_err, out_valid, overrun, sync_err
  );
endinterface

// File: rtl/thermo_frame_decoder.sv
// -----------------------------------------------------------------------------
// thermo_frame_decoder
//   Re-frames a serial thermometer-coded stream (LSB first, FRAME_BITS bits per
//   frame), validates each frame and recovers its level. Results are held in a
//   single valid/ready output register.
//
//   Ports:
//     clock       rising-edge clock
//     clear_n     asynchronous active-low reset
//     bus         thermo_frame_decoder_if.slave (stream in, result out)
//     err_count   saturating count of erroneous frames (optional, see below)
//
//   Optional feature: define THERMO_FRAME_ERR_COUNT_EN to add err_count.
// -----------------------------------------------------------------------------
module thermo_frame_decoder #(
  parameter int FRAME_BITS = 8,
  parameter int LEVEL_W    = 3
) (
  input  logic       clock,
  input  logic       clear_n,
`ifdef THERMO_FRAME_ERR_COUNT_EN
  output logic [7:0] err_count,
`endif
  thermo_frame_decoder_if.slave bus
);

  localparam logic [0:0] HUNT  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [LEVEL_W-1:0] LAST = LEVEL_W'(FRAME_BITS - 1);

  logic [0:0]            state;
  logic [LEVEL_W-1:0]    cnt;
  // Only the first FRAME_BITS-1 bits are stored; the final bit is taken
  // straight from ser_in on the completing edge.
  logic [FRAME_BITS-2:0] shreg;

  logic                  complete;
  logic [FRAME_BITS-1:0] frame;
  logic [LEVEL_W:0]      ones;
  logic [LEVEL_W:0]      ones_m1;
  logic [FRAME_BITS:0]   mask;
  logic [LEVEL_W-1:0]    dec_level;
  logic                  dec_blank;
  logic                  dec_err;

  // A frame_sync on the last bit is a resync, not a completion.
  assign complete = (state == SHIFT) && (cnt == LAST) && !bus.frame_sync;
  assign frame    = {bus.ser_in, shreg};

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ones = '0;
    for (int i = 0; i < FRAME_BITS; i++) begin
      ones = ones + {{LEVEL_W{1'b0}}, frame[i]};
    end
    ones_m1   = ones - {{LEVEL_W{1'b0}}, 1'b1};
    // Valid thermometer code with k ones is exactly (1<<k)-1.
    mask      = ({{FRAME_BITS{1'b0}}, 1'b1} << ones) - {{FRAME_BITS{1'b0}}, 1'b1};
    dec_blank = (ones == '0);
    dec_err   = !dec_blank && (mask != {1'b0, frame});
    dec_level = dec_blank ? '0 : ones_m1[LEVEL_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state         <= HUNT;
      cnt           <= '0;
      shreg         <= '0;
      bus.out_level <= '0;
      bus.out_blank <= 1'b0;
      bus.out_err   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.overrun   <= 1'b0;
      bus.sync_err  <= 1'b0;
    end else begin
      bus.overrun  <= 1'b0;
      bus.sync_err <= 1'b0;

      case (state)
        HUNT: begin
          if (bus.frame_sync) begin
            shreg <= {{(FRAME_BITS-2){1'b0}}, bus.ser_in};
            cnt   <= LEVEL_W'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.frame_sync && (cnt != '0)) begin
            // Drop the partial frame and restart on this bit.
            shreg        <= {{(FRAME_BITS-2){1'b0}}, bus.ser_in};
            cnt          <= LEVEL_W'(1);
            bus.sync_err <= 1'b1;
          end else begin
            for (int i = 0; i < FRAME_BITS - 1; i++) begin
              if (cnt == LEVEL_W'(i)) shreg[i] <= bus.ser_in;
            end
            // Wraps to 0 after the last bit: contiguous frames free-run.
            cnt <= cnt + LEVEL_W'(1);
          end
        end
        default: state <= HUNT;
      endcase

      if (complete) begin
        bus.out_level <= dec_level;
        bus.out_blank <= dec_blank;
        bus.out_err   <= dec_err;
        bus.out_valid <= 1'b1;
        bus.overrun   <= bus.out_valid && !bus.out_ready;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

`ifdef THERMO_FRAME_ERR_COUNT_EN
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      err_count <= '0;
    end else if (complete && dec_err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: doc/thermo_frame_decoder.md
Name: thermo_frame_decoder

Overview:
- Downstream consumer of the serial pattern-generator output.
- The generator emits one bit per clock. Each 8-bit frame is a thermometer code read from the pattern ROM (level a → bits 0..a set), sent LSB first, with the bit index taken from a free-running 3-bit counter.
- This block re-frames the serial stream, checks the thermometer code, and recovers the 3-bit level. The result goes to the consumer through a valid/ready register stage.

Parameters:
- FRAME_BITS, 8, bits per frame. Must be a power of 2 and ≥ 4.
- LEVEL_W, 3, width of the recovered level. Equals log2(FRAME_BITS).

Ports:
- clock, input, 1, single clock; all state changes on its rising edge.
- clear_n, input, 1, asynchronous active-low reset.
- ser_in, input, 1, serial data bit; sampled every rising clock edge.
- frame_sync, input, 1, high on the cycle that ser_in carries bit 0 of a frame.
- out_level, output, LEVEL_W, recovered level: number of ones minus 1.
- out_blank, output, 1, frame contained zero ones (generator disabled).
- out_err, output, 1, frame was not a valid thermometer code.
- out_valid, output, 1, result register holds an unconsumed frame.
- out_ready, input, 1, consumer accepts the result when out_valid && out_ready.
- overrun, output, 1, one-cycle pulse: an unconsumed result was overwritten.
- sync_err, output, 1, one-cycle pulse: frame_sync arrived mid-frame.

Behaviour:
- Reset (clear_n low, asynchronous):
  - State = HUNT, bit counter = 0, shift register = 0.
  - out_level = 0, out_blank = 0, out_err = 0, out_valid = 0, overrun = 0, sync_err = 0.
- States: HUNT and SHIFT.
  - HUNT: ignore ser_in until frame_sync = 1. On that edge, sample ser_in as bit 0, set counter = 1, go to SHIFT.
  - SHIFT: each edge stores ser_in at index counter, then counter increments.
  - When the bit at index FRAME_BITS-1 is stored, the frame is complete. Counter wraps to 0 and the state stays SHIFT, so contiguous frames need no gap.
  - In SHIFT with counter = 0, frame_sync is optional; the block free-runs at the frame period.
- Resync: frame_sync = 1 in SHIFT with counter ≠ 0:
  - Discard the partial frame.
  - Store the current bit as bit 0 and set counter = 1.
  - Pulse sync_err for one cycle.
  - Produce no result for the discarded frame.
- Decode, evaluated on the complete frame f including the bit just sampled. Let k = popcount(f).
  - k = 0 → blank = 1, err = 0, level = 0.
  - f == (1<<k)-1 with k ≥ 1 → blank = 0, err = 0, level = k-1.
  - Otherwise → err = 1, blank = 0, level = k-1 (k ≥ 1 guaranteed here).
- Latency: the result loads into the output register on the same edge that samples the last bit. out_valid is high in the following cycle.
- Handshake:
  - out_valid stays high, and out_level, out_blank and out_err stay stable, until a cycle with out_ready = 1.
  - A transfer with no new result that cycle clears out_valid.
  - Transfer and new result on the same edge → the new result loads, out_valid stays 1, no overrun.
  - New result while out_valid && !out_ready → the new result overwrites the old one, out_valid stays 1, overrun pulses for one cycle.
- Outputs are never combinationally dependent on ser_in.
- Reset asserted mid-frame: all state clears immediately and the block returns to HUNT. The next frame_sync is required.

Optional Feature:
- Macro: THERMO_FRAME_ERR_COUNT_EN.
- Defined:
  - Adds output err_count [7:0]: a saturating count of completed frames with out_err = 1 (holds at 255).
  - Reset to 0 by clear_n.
  - Increments on the edge the erroneous result loads, whether or not that result overwrote an unconsumed one.
- Not defined: port and counter absent. All other behaviour is identical.

Test Plan:
- Reset, then frame_sync with bits 1,1,1,1,0,0,0,0 (LSB first), out_ready = 1 → one cycle after the 8th bit: out_valid = 1, out_level = 3, blank = 0, err = 0.
- Back-to-back frames for ROM levels 0..7, frame_sync only on the first, out_ready = 1 → successive out_level 0,1,…,7 at 8-cycle spacing with no sync_err.
- All-zero frame (en = 0) → out_blank = 1, out_level = 0, out_err = 0. Frame bits 1,0,1,0,0,0,0,0 → out_err = 1, out_level = 1.
- out_ready held 0 across two complete frames (levels 2 then 5) → overrun pulses once, and out_level = 5 remains until out_ready = 1. Then out_valid drops the next cycle.
- frame_sync asserted at bit index 4, then a clean level-6 frame → sync_err pulses once, no result for the partial frame, next result out_level = 6. With the macro defined, 3 error frames give err_count = 3, and 300 error frames give 255.
- clear_n pulsed low at bit 5 of a frame → all outputs 0 asynchronously. Without a new frame_sync, no result ever appears.
